// File: rtl/spl_mem_responder.sv
// Memory-side responder for one SPL channel. Services 64B line read/write requests from an
// internal line array and returns tagged, in-order responses after a fixed latency per direction.
module spl_mem_responder #(
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned RD_LAT     = 4,
  parameter int unsigned WR_LAT     = 2,
  parameter int unsigned Q_DEPTH    = 8
) (
  input  logic         clk,
  input  logic         rst,
  output logic         spl_rd_req_ready,
  input  logic         spl_rd_req_valid,
  input  logic [79:0]  spl_rd_req_bits,
  input  logic         spl_rd_resp_ready,
  output logic         spl_rd_resp_valid,
  output logic [527:0] spl_rd_resp_bits,
  output logic         spl_wr_req_ready,
  input  logic         spl_wr_req_valid,
  input  logic [605:0] spl_wr_req_bits,
  input  logic         spl_wr_resp_ready,
  output logic         spl_wr_resp_valid,
  output logic [16:0]  spl_wr_resp_bits,
  output logic [31:0]  rd_count,
  output logic [31:0]  wr_count
);

  localparam int unsigned Lines = 1 << DEPTH_LOG2;
  localparam int unsigned PtrW  = (Q_DEPTH > 1) ? $clog2(Q_DEPTH) : 1;
  localparam int unsigned CntW  = $clog2(Q_DEPTH + 1);
  localparam logic [CntW-1:0] QFull   = CntW'(Q_DEPTH);
  localparam logic [PtrW-1:0] PtrLast = PtrW'(Q_DEPTH - 1);
  localparam int unsigned AddrLo = 512;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrLast) ? '0 : p + PtrW'(1);
  endfunction

  // Line array; deliberately not reset so contents survive a reset pulse.
  logic [511:0] mem_q [Lines];

  // Request field decode
  logic                  rd_acc, wr_acc, wr_err;
  logic [15:0]           rd_tag, wr_tag;
  logic [DEPTH_LOG2-1:0] rd_idx, wr_idx;
  logic [511:0]          wr_data;
  logic                  unused_bits;

  assign rd_acc  = spl_rd_req_valid & spl_rd_req_ready;
  assign wr_acc  = spl_wr_req_valid & spl_wr_req_ready;
  assign rd_tag  = spl_rd_req_bits[79:64];
  assign rd_idx  = spl_rd_req_bits[DEPTH_LOG2-1:0];
  assign wr_tag  = spl_wr_req_bits[591:576];
  assign wr_idx  = spl_wr_req_bits[AddrLo+DEPTH_LOG2-1:AddrLo];
  assign wr_err  = |spl_wr_req_bits[575:AddrLo+DEPTH_LOG2];
  assign wr_data = spl_wr_req_bits[511:0];
  // Reads alias silently and rsvd is ignored.
  assign unused_bits = ^{spl_rd_req_bits[63:DEPTH_LOG2], spl_wr_req_bits[605:592]};

  // Final-stage view of each pipe; with LAT==1 the accept itself is the final stage.
  logic                  rd_fin_v, wr_fin_v;
  logic [15:0]           rd_fin_tag;
  logic [DEPTH_LOG2-1:0] rd_fin_idx;
  logic [16:0]           wr_fin_resp;

  if (RD_LAT > 1) begin : g_rd_pipe
    localparam int unsigned N = RD_LAT - 1;
    logic [N-1:0]          v_q;
    logic [15:0]           tag_q [N];
    logic [DEPTH_LOG2-1:0] idx_q [N];
    // Shift read tag/index toward the sampling stage
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        v_q <= '0;
        for (int i = 0; i < int'(N); i++) begin
          tag_q[i] <= '0;
          idx_q[i] <= '0;
        end
      end else begin
        v_q[0]   <= rd_acc;
        tag_q[0] <= rd_tag;
        idx_q[0] <= rd_idx;
        for (int i = 1; i < int'(N); i++) begin
          v_q[i]   <= v_q[i-1];
          tag_q[i] <= tag_q[i-1];
          idx_q[i] <= idx_q[i-1];
        end
      end
    end
    assign rd_fin_v   = v_q[N-1];
    assign rd_fin_tag = tag_q[N-1];
    assign rd_fin_idx = idx_q[N-1];
  end else begin : g_rd_direct
    assign rd_fin_v   = rd_acc;
    assign rd_fin_tag = rd_tag;
    assign rd_fin_idx = rd_idx;
  end

  if (WR_LAT > 1) begin : g_wr_pipe
    localparam int unsigned N = WR_LAT - 1;
    logic [N-1:0] v_q;
    logic [16:0]  resp_q [N];
    // Delay the {err, tag} write response
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        v_q <= '0;
        for (int i = 0; i < int'(N); i++) resp_q[i] <= '0;
      end else begin
        v_q[0]    <= wr_acc;
        resp_q[0] <= {wr_err, wr_tag};
        for (int i = 1; i < int'(N); i++) begin
          v_q[i]    <= v_q[i-1];
          resp_q[i] <= resp_q[i-1];
        end
      end
    end
    assign wr_fin_v    = v_q[N-1];
    assign wr_fin_resp = resp_q[N-1];
  end else begin : g_wr_direct
    assign wr_fin_v    = wr_acc;
    assign wr_fin_resp = {wr_err, wr_tag};
  end

  // Response queues and credit state
  logic [527:0]    rdq_q [Q_DEPTH];
  logic [16:0]     wrq_q [Q_DEPTH];
  logic [PtrW-1:0] rdq_wp_q, rdq_wp_d, rdq_rp_q, rdq_rp_d;
  logic [PtrW-1:0] wrq_wp_q, wrq_wp_d, wrq_rp_q, wrq_rp_d;
  logic [CntW-1:0] rdq_cnt_q, rdq_cnt_d, wrq_cnt_q, wrq_cnt_d;
  logic [CntW-1:0] rd_out_q, rd_out_d, wr_out_q, wr_out_d;
  logic            rd_rdy_q, rd_rdy_d, wr_rdy_q, wr_rdy_d;
  logic [31:0]     rd_count_q, rd_count_d, wr_count_q, wr_count_d;
  logic            rd_deq, wr_deq;

  assign spl_rd_resp_valid = (rdq_cnt_q != '0);
  assign spl_wr_resp_valid = (wrq_cnt_q != '0);
  assign spl_rd_resp_bits  = rdq_q[rdq_rp_q];
  assign spl_wr_resp_bits  = wrq_q[wrq_rp_q];
  assign spl_rd_req_ready  = rd_rdy_q;
  assign spl_wr_req_ready  = wr_rdy_q;
  assign rd_count          = rd_count_q;
  assign wr_count          = wr_count_q;
  assign rd_deq            = spl_rd_resp_valid & spl_rd_resp_ready;
  assign wr_deq            = spl_wr_resp_valid & spl_wr_resp_ready;

  // Array write on the accept edge; a read sampling the same line this cycle sees the old data
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_idx] <= wr_data;
  end

  // Queue payload storage; the credit rule guarantees the write slot is always free
  always_ff @(posedge clk) begin
    if (rd_fin_v) rdq_q[rdq_wp_q] <= {rd_fin_tag, mem_q[rd_fin_idx]};
    if (wr_fin_v) wrq_q[wrq_wp_q] <= wr_fin_resp;
  end

  // Next-state for pointers, occupancy, credits and counters
  always_comb begin
    rdq_wp_d   = rd_fin_v ? ptr_inc(rdq_wp_q) : rdq_wp_q;
    rdq_rp_d   = rd_deq ? ptr_inc(rdq_rp_q) : rdq_rp_q;
    wrq_wp_d   = wr_fin_v ? ptr_inc(wrq_wp_q) : wrq_wp_q;
    wrq_rp_d   = wr_deq ? ptr_inc(wrq_rp_q) : wrq_rp_q;
    rdq_cnt_d  = rdq_cnt_q + CntW'(rd_fin_v) - CntW'(rd_deq);
    wrq_cnt_d  = wrq_cnt_q + CntW'(wr_fin_v) - CntW'(wr_deq);
    // Outstanding counts pipe plus queue, so pipe entries already own a queue slot
    rd_out_d   = rd_out_q + CntW'(rd_acc) - CntW'(rd_deq);
    wr_out_d   = wr_out_q + CntW'(wr_acc) - CntW'(wr_deq);
    rd_rdy_d   = (rd_out_d < QFull);
    wr_rdy_d   = (wr_out_d < QFull);
    rd_count_d = rd_count_q + 32'(rd_acc);
    wr_count_d = wr_count_q + 32'(wr_acc);
  end

  // Control state; readies held low in reset and registered so resp_ready never reaches them
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdq_wp_q   <= '0;
      rdq_rp_q   <= '0;
      wrq_wp_q   <= '0;
      wrq_rp_q   <= '0;
      rdq_cnt_q  <= '0;
      wrq_cnt_q  <= '0;
      rd_out_q   <= '0;
      wr_out_q   <= '0;
      rd_rdy_q   <= 1'b0;
      wr_rdy_q   <= 1'b0;
      rd_count_q <= '0;
      wr_count_q <= '0;
    end else begin
      rdq_wp_q   <= rdq_wp_d;
      rdq_rp_q   <= rdq_rp_d;
      wrq_wp_q   <= wrq_wp_d;
      wrq_rp_q   <= wrq_rp_d;
      rdq_cnt_q  <= rdq_cnt_d;
      wrq_cnt_q  <= wrq_cnt_d;
      rd_out_q   <= rd_out_d;
      wr_out_q   <= wr_out_d;
      rd_rdy_q   <= rd_rdy_d;
      wr_rdy_q   <= wr_rdy_d;
      rd_count_q <= rd_count_d;
      wr_count_q <= wr_count_d;
    end
  end

endmodule

// File: tb/tb_spl_mem_responder.sv
// Bench for spl_mem_responder: directed scenarios plus a randomized run, all responses checked
// against a cycle-indexed reference memory and per-direction expected-response queues.
module tb_spl_mem_responder;

  localparam int unsigned DL = 10;
  localparam int unsigned RL = 4;
  localparam int unsigned WL = 2;
  localparam int unsigned QD = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         spl_rd_req_ready, spl_rd_req_valid;
  logic [79:0]  spl_rd_req_bits;
  logic         spl_rd_resp_ready, spl_rd_resp_valid;
  logic [527:0] spl_rd_resp_bits;
  logic         spl_wr_req_ready, spl_wr_req_valid;
  logic [605:0] spl_wr_req_bits;
  logic         spl_wr_resp_ready, spl_wr_resp_valid;
  logic [16:0]  spl_wr_resp_bits;
  logic [31:0]  rd_count, wr_count;

  spl_mem_responder #(.DEPTH_LOG2(DL), .RD_LAT(RL), .WR_LAT(WL), .Q_DEPTH(QD)) dut (
    .clk(clk), .rst(rst),
    .spl_rd_req_ready(spl_rd_req_ready), .spl_rd_req_valid(spl_rd_req_valid),
    .spl_rd_req_bits(spl_rd_req_bits), .spl_rd_resp_ready(spl_rd_resp_ready),
    .spl_rd_resp_valid(spl_rd_resp_valid), .spl_rd_resp_bits(spl_rd_resp_bits),
    .spl_wr_req_ready(spl_wr_req_ready), .spl_wr_req_valid(spl_wr_req_valid),
    .spl_wr_req_bits(spl_wr_req_bits), .spl_wr_resp_ready(spl_wr_resp_ready),
    .spl_wr_resp_valid(spl_wr_resp_valid), .spl_wr_resp_bits(spl_wr_resp_bits),
    .rd_count(rd_count), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  bit mon_on = 1'b0;

  typedef struct {
    logic [15:0]  tag;
    int           idx;
    int           due;
    bit           done;
    bit           known;
    logic [511:0] data;
  } rd_exp_t;
  typedef struct {
    logic [15:0] tag;
    logic        err;
  } wr_exp_t;

  rd_exp_t      rd_exp[$];
  wr_exp_t      wr_exp[$];
  logic [511:0] ref_mem [1024];
  bit           ref_known [1024];
  int unsigned  rd_model_cnt = 0, wr_model_cnt = 0;
  bit           rd_hold = 1'b0, wr_hold = 1'b0;
  logic [527:0] rd_hold_bits;
  logic [16:0]  wr_hold_bits;
  logic [511:0] val7_new;

  // Reference model: a read returns the line as it stands when its sampling cycle
  // (accept + RL - 1) begins; a write updates the line at the end of its accept cycle.
  always @(negedge clk) begin : mon
    rd_exp_t e;
    wr_exp_t w;
    logic [63:0] a;
    cyc++;
    if (mon_on) begin
      vectors++;
      if (spl_rd_req_ready !== (rd_exp.size() < QD)) begin
        miscompares++;
        $display("FAIL rd_credit cyc=%0d got=%b want=%b", cyc, spl_rd_req_ready,
                 rd_exp.size() < QD);
      end
      vectors++;
      if (spl_wr_req_ready !== (wr_exp.size() < QD)) begin
        miscompares++;
        $display("FAIL wr_credit cyc=%0d got=%b want=%b", cyc, spl_wr_req_ready,
                 wr_exp.size() < QD);
      end
      vectors++;
      if (rd_count !== rd_model_cnt || wr_count !== wr_model_cnt) begin
        miscompares++;
        $display("FAIL counters cyc=%0d got=%0d/%0d want=%0d/%0d", cyc, rd_count, wr_count,
                 rd_model_cnt, wr_model_cnt);
      end
      if (rd_hold) begin
        vectors++;
        if (spl_rd_resp_valid !== 1'b1 || spl_rd_resp_bits !== rd_hold_bits) begin
          miscompares++;
          $display("FAIL rd_hold cyc=%0d got v=%b tag=%h want v=1 tag=%h", cyc,
                   spl_rd_resp_valid, spl_rd_resp_bits[527:512], rd_hold_bits[527:512]);
        end
      end
      if (wr_hold) begin
        vectors++;
        if (spl_wr_resp_valid !== 1'b1 || spl_wr_resp_bits !== wr_hold_bits) begin
          miscompares++;
          $display("FAIL wr_hold cyc=%0d got v=%b bits=%h want v=1 bits=%h", cyc,
                   spl_wr_resp_valid, spl_wr_resp_bits, wr_hold_bits);
        end
      end
      if (spl_rd_req_valid && spl_rd_req_ready) begin
        e.tag = spl_rd_req_bits[79:64];
        e.idx = int'(spl_rd_req_bits[9:0]);
        e.due = cyc + int'(RL) - 1;
        e.done = 1'b0;
        e.known = 1'b0;
        e.data = '0;
        rd_exp.push_back(e);
        rd_model_cnt++;
      end
      foreach (rd_exp[i]) begin
        if (!rd_exp[i].done && rd_exp[i].due == cyc) begin
          rd_exp[i].done  = 1'b1;
          rd_exp[i].known = ref_known[rd_exp[i].idx];
          rd_exp[i].data  = ref_mem[rd_exp[i].idx];
        end
      end
      if (spl_wr_req_valid && spl_wr_req_ready) begin
        a = spl_wr_req_bits[575:512];
        ref_mem[int'(a[9:0])] = spl_wr_req_bits[511:0];
        ref_known[int'(a[9:0])] = 1'b1;
        w.tag = spl_wr_req_bits[591:576];
        w.err = (a >= 64'd1024);
        wr_exp.push_back(w);
        wr_model_cnt++;
      end
      if (spl_rd_resp_valid && spl_rd_resp_ready) begin
        vectors++;
        if (rd_exp.size() == 0) begin
          miscompares++;
          $display("FAIL rd_resp_unexpected cyc=%0d got tag=%h want none", cyc,
                   spl_rd_resp_bits[527:512]);
        end else begin
          e = rd_exp.pop_front();
          if (!e.done || spl_rd_resp_bits[527:512] !== e.tag ||
              (e.known && spl_rd_resp_bits[511:0] !== e.data)) begin
            miscompares++;
            $display("FAIL rd_resp cyc=%0d got tag=%h data=%h want tag=%h data=%h ready=%b",
                     cyc, spl_rd_resp_bits[527:512], spl_rd_resp_bits[63:0], e.tag,
                     e.data[63:0], e.done);
          end
        end
      end
      if (spl_wr_resp_valid && spl_wr_resp_ready) begin
        vectors++;
        if (wr_exp.size() == 0) begin
          miscompares++;
          $display("FAIL wr_resp_unexpected cyc=%0d got=%h want none", cyc, spl_wr_resp_bits);
        end else begin
          w = wr_exp.pop_front();
          if (spl_wr_resp_bits !== {w.err, w.tag}) begin
            miscompares++;
            $display("FAIL wr_resp cyc=%0d got=%h want=%h", cyc, spl_wr_resp_bits,
                     {w.err, w.tag});
          end
        end
      end
      rd_hold = spl_rd_resp_valid && !spl_rd_resp_ready;
      rd_hold_bits = spl_rd_resp_bits;
      wr_hold = spl_wr_resp_valid && !spl_wr_resp_ready;
      wr_hold_bits = spl_wr_resp_bits;
    end else begin
      rd_hold = 1'b0;
      wr_hold = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [63:0] rand_addr();
    if ($urandom_range(0, 99) < 4) return {32'($urandom), 32'($urandom)} | 64'h400;
    return 64'($urandom_range(0, 31));
  endfunction

  task automatic send_rd(input logic [15:0] tag, input logic [63:0] addr, output int acc);
    acc = -1;
    spl_rd_req_valid = 1'b1;
    spl_rd_req_bits = {tag, addr};
    for (int k = 0; k < 100 && acc < 0; k++) begin
      samp();
      if (spl_rd_req_ready) acc = cyc;
      tick();
    end
    spl_rd_req_valid = 1'b0;
  endtask

  task automatic send_wr(input logic [15:0] tag, input logic [63:0] addr,
                         input logic [511:0] data, output int acc);
    acc = -1;
    spl_wr_req_valid = 1'b1;
    spl_wr_req_bits = {14'h0, tag, addr, data};
    for (int k = 0; k < 100 && acc < 0; k++) begin
      samp();
      if (spl_wr_req_ready) acc = cyc;
      tick();
    end
    spl_wr_req_valid = 1'b0;
  endtask

  task automatic wait_rd(output int seen, output logic [527:0] bits);
    seen = -1;
    bits = '0;
    for (int k = 0; k < 40 && seen < 0; k++) begin
      samp();
      if (spl_rd_resp_valid) begin
        seen = cyc;
        bits = spl_rd_resp_bits;
      end
      tick();
    end
  endtask

  task automatic wait_wr(output int seen, output logic [16:0] bits);
    seen = -1;
    bits = '0;
    for (int k = 0; k < 40 && seen < 0; k++) begin
      samp();
      if (spl_wr_resp_valid) begin
        seen = cyc;
        bits = spl_wr_resp_bits;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    spl_rd_req_valid = 1'b0; spl_rd_req_bits = '0; spl_rd_resp_ready = 1'b1;
    spl_wr_req_valid = 1'b0; spl_wr_req_bits = '0; spl_wr_resp_ready = 1'b1;
    #12;
    vectors++;
    if ({spl_rd_req_ready, spl_wr_req_ready, spl_rd_resp_valid, spl_wr_resp_valid} !== 4'b0 ||
        rd_count !== 32'd0 || wr_count !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_state got rdy=%b%b vld=%b%b cnt=%0d/%0d want all zero",
               spl_rd_req_ready, spl_wr_req_ready, spl_rd_resp_valid, spl_wr_resp_valid,
               rd_count, wr_count);
    end
    @(posedge clk);
    #1 rst = 1'b1;
    tick();
    vectors++;
    if (spl_rd_req_ready !== 1'b1 || spl_wr_req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL release_ready got=%b%b want=11", spl_rd_req_ready, spl_wr_req_ready);
    end
    mon_on = 1'b1;
  endtask

  task automatic test_basic();
    int cw, cr, seen;
    logic [16:0] wb;
    logic [527:0] rb;
    logic [511:0] a = rand512();
    send_wr(16'h11, 64'h5, a, cw);
    wait_wr(seen, wb);
    vectors++;
    if (cw < 0 || seen != cw + int'(WL)) begin
      miscompares++;
      $display("FAIL wr_latency got=%0d want=%0d", seen - cw, WL);
    end
    vectors++;
    if (wb !== {1'b0, 16'h11}) begin
      miscompares++;
      $display("FAIL wr_bits got=%h want=%h", wb, {1'b0, 16'h11});
    end
    send_rd(16'h22, 64'h5, cr);
    wait_rd(seen, rb);
    vectors++;
    if (cr < 0 || seen != cr + int'(RL)) begin
      miscompares++;
      $display("FAIL rd_latency got=%0d want=%0d", seen - cr, RL);
    end
    vectors++;
    if (rb !== {16'h22, a}) begin
      miscompares++;
      $display("FAIL rd_bits got=%h want=%h", rb[527:448], {16'h22, a[511:448]});
    end
  endtask

  task automatic test_backpressure();
    int acc = 0;
    spl_rd_resp_ready = 1'b0;
    spl_rd_req_valid = 1'b1;
    for (int k = 0; k < 12; k++) begin
      spl_rd_req_bits = {16'h100 + 16'(acc), 64'(acc)};
      samp();
      if (spl_rd_req_ready) acc++;
      tick();
    end
    vectors++;
    if (acc != int'(QD)) begin
      miscompares++;
      $display("FAIL bp_accepted got=%0d want=%0d", acc, QD);
    end
    samp();
    vectors++;
    if (spl_rd_req_ready !== 1'b0 || spl_rd_resp_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_stalled got rdy=%b vld=%b want rdy=0 vld=1", spl_rd_req_ready,
               spl_rd_resp_valid);
    end
    tick();
    spl_rd_resp_ready = 1'b1;
    for (int k = 0; k < 100 && acc < 12; k++) begin
      spl_rd_req_bits = {16'h100 + 16'(acc), 64'(acc)};
      samp();
      if (spl_rd_req_ready) acc++;
      tick();
    end
    spl_rd_req_valid = 1'b0;
    for (int k = 0; k < 50 && rd_exp.size() != 0; k++) tick();
    vectors++;
    if (acc != 12 || rd_exp.size() != 0) begin
      miscompares++;
      $display("FAIL bp_drain got acc=%0d left=%0d want acc=12 left=0", acc, rd_exp.size());
    end
  endtask

  task automatic test_err();
    int cw, cr, seen;
    logic [16:0] wb;
    logic [527:0] rb;
    logic [511:0] b = rand512();
    send_wr(16'h33, 64'h400, b, cw);
    wait_wr(seen, wb);
    vectors++;
    if (seen < 0 || wb !== {1'b1, 16'h33}) begin
      miscompares++;
      $display("FAIL err_flag got=%h want=%h", wb, {1'b1, 16'h33});
    end
    send_rd(16'h44, 64'h0, cr);
    wait_rd(seen, rb);
    vectors++;
    if (cr < 0 || seen < 0 || rb !== {16'h44, b}) begin
      miscompares++;
      $display("FAIL alias_read got=%h want=%h", rb[527:448], {16'h44, b[511:448]});
    end
  endtask

  // A write landing in the cycle the read samples the array must not be visible to it.
  task automatic test_same_cycle();
    int cw, ra, wa, seen;
    logic [16:0] wb;
    logic [527:0] rb;
    logic [511:0] old_v = rand512();
    val7_new = rand512();
    send_wr(16'h55, 64'h7, old_v, cw);
    wait_wr(seen, wb);
    spl_rd_req_valid = 1'b1;
    spl_rd_req_bits = {16'h66, 64'h7};
    samp();
    ra = spl_rd_req_ready ? cyc : -1;
    tick();
    spl_rd_req_valid = 1'b0;
    repeat (RL - 2) tick();
    spl_wr_req_valid = 1'b1;
    spl_wr_req_bits = {14'h0, 16'h77, 64'h7, val7_new};
    samp();
    wa = spl_wr_req_ready ? cyc : -1;
    tick();
    spl_wr_req_valid = 1'b0;
    vectors++;
    if (ra < 0 || wa != ra + int'(RL) - 1) begin
      miscompares++;
      $display("FAIL sc_alignment got=%0d want=%0d", wa - ra, RL - 1);
    end
    wait_rd(seen, rb);
    vectors++;
    if (rb !== {16'h66, old_v}) begin
      miscompares++;
      $display("FAIL sc_old got=%h want=%h", rb[527:448], {16'h66, old_v[511:448]});
    end
    wait_wr(seen, wb);
    send_rd(16'h67, 64'h7, ra);
    wait_rd(seen, rb);
    vectors++;
    if (rb !== {16'h67, val7_new}) begin
      miscompares++;
      $display("FAIL sc_new got=%h want=%h", rb[527:448], {16'h67, val7_new[511:448]});
    end
  endtask

  task automatic test_reset_mid();
    int stale = 0, cr, seen;
    logic [527:0] rb;
    spl_rd_resp_ready = 1'b0;
    spl_rd_req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      spl_rd_req_bits = {16'h90 + 16'(i), 64'(i)};
      tick();
    end
    spl_rd_req_valid = 1'b0;
    repeat (RL - 2) tick();
    vectors++;
    if (spl_rd_resp_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL rm_prevalid got=%b want=1", spl_rd_resp_valid);
    end
    mon_on = 1'b0;
    #2 rst = 1'b0;
    #1;
    vectors++;
    if ({spl_rd_req_ready, spl_wr_req_ready, spl_rd_resp_valid, spl_wr_resp_valid} !== 4'b0 ||
        rd_count !== 32'd0 || wr_count !== 32'd0) begin
      miscompares++;
      $display("FAIL rm_async got rdy=%b%b vld=%b%b cnt=%0d/%0d want all zero",
               spl_rd_req_ready, spl_wr_req_ready, spl_rd_resp_valid, spl_wr_resp_valid,
               rd_count, wr_count);
    end
    rd_exp.delete();
    wr_exp.delete();
    rd_model_cnt = 0;
    wr_model_cnt = 0;
    spl_rd_resp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    tick();
    mon_on = 1'b1;
    for (int k = 0; k < 10; k++) begin
      samp();
      if (spl_rd_resp_valid) stale++;
      tick();
    end
    vectors++;
    if (stale != 0) begin
      miscompares++;
      $display("FAIL rm_stale got=%0d want=0", stale);
    end
    send_rd(16'h99, 64'h7, cr);
    wait_rd(seen, rb);
    vectors++;
    if (cr < 0 || rb !== {16'h99, val7_new}) begin
      miscompares++;
      $display("FAIL rm_persist got=%h want=%h", rb[527:448], {16'h99, val7_new[511:448]});
    end
  endtask

  function automatic int pick_rate();
    case ($urandom_range(0, 2))
      0: return 15;
      1: return 50;
      default: return 95;
    endcase
  endfunction

  task automatic test_random();
    bit rd_done = 1'b0, wr_done = 1'b0;
    int prd = 70, pwr = 70;
    for (int n = 0; n < 12000; n++) begin
      if (n % 400 == 0) begin
        prd = pick_rate();
        pwr = pick_rate();
      end
      if (rd_done) spl_rd_req_valid = 1'b0;
      if (wr_done) spl_wr_req_valid = 1'b0;
      if (!spl_rd_req_valid && $urandom_range(0, 99) < 60) begin
        spl_rd_req_valid = 1'b1;
        spl_rd_req_bits = {16'($urandom), rand_addr()};
      end
      if (!spl_wr_req_valid && $urandom_range(0, 99) < 60) begin
        spl_wr_req_valid = 1'b1;
        spl_wr_req_bits = {14'h0, 16'($urandom), rand_addr(), rand512()};
      end
      spl_rd_resp_ready = ($urandom_range(0, 99) < prd);
      spl_wr_resp_ready = ($urandom_range(0, 99) < pwr);
      samp();
      rd_done = spl_rd_req_valid && spl_rd_req_ready;
      wr_done = spl_wr_req_valid && spl_wr_req_ready;
      tick();
    end
    spl_rd_req_valid = 1'b0;
    spl_wr_req_valid = 1'b0;
    spl_rd_resp_ready = 1'b1;
    spl_wr_resp_ready = 1'b1;
    for (int k = 0; k < 100 && (rd_exp.size() != 0 || wr_exp.size() != 0); k++) tick();
    vectors++;
    if (rd_exp.size() != 0 || wr_exp.size() != 0) begin
      miscompares++;
      $display("FAIL rand_drain got left=%0d/%0d want 0/0", rd_exp.size(), wr_exp.size());
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d got timeout want completion", cyc);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_err();
    test_same_cycle();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
